// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter: state encoding and width defaults.
// Optional build macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int AW_DEF       = 5;
    localparam int DW_DEF       = 32;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    // Grant state for a master index (0 -> GNT0, 1 -> GNT1).
    function automatic arb_state_e grant_state(input logic master);
        return master ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating hold counter: counts granted cycles while the other master waits.
// terminal is high once the count reaches MAX_HOLD-1.
module arb_hold_counter #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for a shared synchronous memory (cen/wen/addr/din/dout).
// Build macro MEM_ARB_ROUND_ROBIN_EN: IDLE ties go to the master not granted last; otherwise master 0 wins.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HCW      = $clog2(MAX_HOLD + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           m0_req,
    input  logic           m0_wr,
    input  logic [AW-1:0]  m0_addr,
    input  logic [DW-1:0]  m0_din,
    output logic           m0_grant,
    output logic           m0_rvalid,
    output logic [DW-1:0]  m0_rdata,
    input  logic           m1_req,
    input  logic           m1_wr,
    input  logic [AW-1:0]  m1_addr,
    input  logic [DW-1:0]  m1_din,
    output logic           m1_grant,
    output logic           m1_rvalid,
    output logic [DW-1:0]  m1_rdata,
    output logic           mem_cen,
    output logic           mem_wen,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_din,
    input  logic [DW-1:0]  mem_dout,
    output logic [1:0]     dbg_state,
    output logic [HCW-1:0] dbg_hold_cnt,
    output logic           dbg_last
);

    // Handshake: a master raises req and holds it (with stable wr/addr/din for the
    // current word) for the whole transfer; every cycle where grant & req are both
    // high is one memory access. grant follows req by one cycle, and a read access
    // returns data one cycle later with a single-cycle rvalid.

    arb_state_e      state, next_state;
    logic            last;
    logic            acc0, acc1;
    logic            hold_clear, hold_enable, hold_term;
    logic [HCW-1:0]  hold_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    next_state = grant_state(~last);
`else
                    next_state = GNT0;
`endif
                end else if (m0_req) begin
                    next_state = GNT0;
                end else if (m1_req) begin
                    next_state = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    next_state = m1_req ? GNT1 : IDLE;
                end else if (m1_req && hold_term) begin
                    next_state = GNT1;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    next_state = m0_req ? GNT0 : IDLE;
                end else if (m0_req && hold_term) begin
                    next_state = GNT0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The counter only runs while the waiting master is actually asking.
    assign hold_clear  = (state == IDLE) || (next_state != state);
    assign hold_enable = ((state == GNT0) && m1_req) || ((state == GNT1) && m0_req);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (HCW)
    ) u_hold_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (hold_clear),
        .enable   (hold_enable),
        .count    (hold_cnt),
        .terminal (hold_term)
    );

    // last: 0 = master 0 granted most recently, 1 = master 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else if ((next_state == GNT0) && (state != GNT0)) begin
            last <= 1'b0;
        end else if ((next_state == GNT1) && (state != GNT1)) begin
            last <= 1'b1;
        end
    end

    assign m0_grant = (state == GNT0);
    assign m1_grant = (state == GNT1);
    assign acc0     = m0_grant & m0_req;
    assign acc1     = m1_grant & m1_req;

    always_comb begin
        mem_cen  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (acc0) begin
            mem_cen  = 1'b1;
            mem_wen  = m0_wr;
            mem_addr = m0_addr;
            mem_din  = m0_din;
        end else if (acc1) begin
            mem_cen  = 1'b1;
            mem_wen  = m1_wr;
            mem_addr = m1_addr;
            mem_din  = m1_din;
        end
    end

    // Read-return tag: memory data lands one cycle after the access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= acc0 & ~m0_wr;
            m1_rvalid <= acc1 & ~m1_wr;
        end
    end

    assign m0_rdata = mem_dout;
    assign m1_rdata = mem_dout;

    assign dbg_state    = state;
    assign dbg_hold_cnt = hold_cnt;
    assign dbg_last     = last;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a bus-ownership reference model.
module tb_mem_bus_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;
    localparam int HCW      = $clog2(MAX_HOLD + 1);

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           m0_req = 1'b0, m0_wr = 1'b0;
    logic [AW-1:0]  m0_addr = '0;
    logic [DW-1:0]  m0_din = '0;
    logic           m1_req = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0]  m1_addr = '0;
    logic [DW-1:0]  m1_din = '0;
    logic           m0_grant, m0_rvalid, m1_grant, m1_rvalid;
    logic [DW-1:0]  m0_rdata, m1_rdata;
    logic           mem_cen, mem_wen;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_din;
    logic [DW-1:0]  mem_dout;
    logic [1:0]     dbg_state;
    logic [HCW-1:0] dbg_hold_cnt;
    logic           dbg_last;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_req       (m0_req),
        .m0_wr        (m0_wr),
        .m0_addr      (m0_addr),
        .m0_din       (m0_din),
        .m0_grant     (m0_grant),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_wr        (m1_wr),
        .m1_addr      (m1_addr),
        .m1_din       (m1_din),
        .m1_grant     (m1_grant),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .mem_cen      (mem_cen),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .dbg_state    (dbg_state),
        .dbg_hold_cnt (dbg_hold_cnt),
        .dbg_last     (dbg_last)
    );

    // Synchronous memory attached to the arbiter's memory port.
    logic [DW-1:0] mem [0:31];
    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) mem[mem_addr] <= mem_din;
            else         mem_dout <= mem[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = bus free, 1 = master 0 owns it, 2 = master 1 owns it.
    // streak: cycles the owner kept the bus while the other master was asking.
    int            owner;
    int            streak;
    int            last_owner;
    int            rv_who;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_q [$];

    task automatic model_reset();
        owner      = 0;
        streak     = 0;
        last_owner = 1;
        rv_who     = -1;
    endtask

    // Expected outputs for the current cycle given model state and driven inputs.
    task automatic compare_outputs();
        logic a0, a1;
        a0 = (owner == 1) && m0_req;
        a1 = (owner == 2) && m1_req;
        check("m0_grant", m0_grant, owner == 1);
        check("m1_grant", m1_grant, owner == 2);
        check("grant_overlap", m0_grant & m1_grant, 0);
        check("mem_cen", mem_cen, a0 | a1);
        check("mem_wen", mem_wen, a0 ? m0_wr : (a1 ? m1_wr : 1'b0));
        check("mem_addr", mem_addr, a0 ? m0_addr : (a1 ? m1_addr : '0));
        check("mem_din", mem_din, a0 ? m0_din : (a1 ? m1_din : '0));
        check("m0_rvalid", m0_rvalid, rv_who == 0);
        check("m1_rvalid", m1_rvalid, rv_who == 1);
        if (rv_who == 0) check("m0_rdata", m0_rdata, rv_data);
        if (rv_who == 1) check("m1_rdata", m1_rdata, rv_data);
        check("state", dbg_state, owner);
        check("hold_cnt", dbg_hold_cnt, streak);
        check("last", dbg_last, last_owner);
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_advance();
        int  nxt;
        logic mine, theirs;
        rv_who = -1;
        if (owner == 1 && m0_req) begin
            if (m0_wr) ref_mem[m0_addr] = m0_din;
            else begin rv_who = 0; rv_data = ref_mem[m0_addr]; end
        end
        if (owner == 2 && m1_req) begin
            if (m1_wr) ref_mem[m1_addr] = m1_din;
            else begin rv_who = 1; rv_data = ref_mem[m1_addr]; end
        end
        if (rv_who >= 0) exp_q.push_back(rv_data);

        mine   = (owner == 1) ? m0_req : m1_req;
        theirs = (owner == 1) ? m1_req : m0_req;
        if (owner == 0) begin
            if (m0_req && m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                nxt = (last_owner == 0) ? 2 : 1;
`else
                nxt = 1;
`endif
            end else if (m0_req) nxt = 1;
            else if (m1_req)     nxt = 2;
            else                 nxt = 0;
        end else if (!mine) begin
            nxt = theirs ? 3 - owner : 0;
        end else if (theirs && streak >= MAX_HOLD - 1) begin
            nxt = 3 - owner;
        end else begin
            nxt = owner;
        end

        if (nxt != owner || nxt == 0) streak = 0;
        else if (theirs)              streak = (streak + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : streak + 1;
        if (nxt != owner && nxt != 0) last_owner = nxt - 1;
        owner = nxt;
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drive inputs, check at the falling edge, advance.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req = r0; m0_wr = w0; m0_addr = a0; m0_din = d0;
        m1_req = r1; m1_wr = w1; m1_addr = a1; m1_din = d1;
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    int m1_pulses;
    always @(negedge clk) if (m1_rvalid) m1_pulses++;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_outputs();
        reset_n = 1'b1;
        @(posedge clk);
        model_advance();
        #1;

        // Preload: master 0 writes word i to address i.
        step(1, 1, 5'd0, 32'd0, 0, 0, '0, '0);
        for (int i = 0; i < 32; i++) step(1, 1, AW'(i), DW'(i), 0, 0, '0, '0);
        idle(2);

        // Single master write then read of address 5.
        step(1, 1, 5'h05, 32'h0000_0005, 0, 0, '0, '0);
        step(1, 1, 5'h05, 32'h0000_0005, 0, 0, '0, '0);
        step(1, 0, 5'h05, '0, 0, 0, '0, '0);
        exp_q.delete();
        idle(1);
        check("m0_read_back", m0_rdata, 32'h0000_0005);
        idle(1);

        // Contention from IDLE: master 0 first, forced over to master 1 after MAX_HOLD.
        for (int i = 0; i < 9; i++) step(1, 0, 5'h07, '0, 1, 0, 5'h0A, '0);
        idle(2);

        // Release handoff: master 1 holds while master 0 waits, then master 1 lets go.
        step(0, 0, '0, '0, 1, 1, 5'h10, 32'hAAAA_0000);
        step(0, 0, '0, '0, 1, 1, 5'h10, 32'hAAAA_0001);
        step(1, 0, 5'h02, '0, 1, 1, 5'h11, 32'hAAAA_0002);
        step(1, 0, 5'h02, '0, 1, 1, 5'h12, 32'hAAAA_0003);
        step(1, 0, 5'h02, '0, 0, 0, '0, '0);
        step(1, 0, 5'h02, '0, 0, 0, '0, '0);
        idle(2);

        // Back-to-back reads by master 1 of addresses 1..3.
        m1_pulses = 0;
        exp_q.delete();
        step(0, 0, '0, '0, 1, 0, 5'h01, '0);
        step(0, 0, '0, '0, 1, 0, 5'h01, '0);
        step(0, 0, '0, '0, 1, 0, 5'h02, '0);
        step(0, 0, '0, '0, 1, 0, 5'h03, '0);
        idle(2);
        check("m1_pulse_count", m1_pulses, 3);
        check("m1_burst_depth", exp_q.size(), 3);
        for (int i = 0; i < 3 && i < exp_q.size(); i++) check("m1_burst_data", exp_q[i], DW'(i + 1));

        // Reset in the middle of a read transfer.
        step(1, 0, 5'h04, '0, 0, 0, '0, '0);
        step(1, 0, 5'h04, '0, 0, 0, '0, '0);
        reset_n = 1'b0;
        #1;
        check("rst_m0_grant", m0_grant, 0);
        check("rst_m1_grant", m1_grant, 0);
        check("rst_mem_cen", mem_cen, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_state", dbg_state, 0);
        model_reset();
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        compare_outputs();
        reset_n = 1'b1;
        @(posedge clk);
        model_advance();
        #1;

        // Randomized traffic with sticky requests.
        for (int i = 0; i < 600; i++) begin
            logic r0, r1;
            r0 = ($urandom_range(0, 3) != 0) ? m0_req : ~m0_req;
            r1 = ($urandom_range(0, 3) != 0) ? m1_req : ~m1_req;
            step(r0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom(),
                 r1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom());
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared 32-word x 32-bit synchronous memory (cen/wen/addr/din/dout).
- Grants one requester at a time and muxes that master's command onto the memory port.
- Returns read data to the master with a registered valid strobe.
- Bounds bus hold time so neither master can starve the other.

Parameters:
- AW, 5, memory address width (32 words)
- DW, 32, data width
- MAX_HOLD, 4, max consecutive granted cycles while the other master waits (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 requests the bus (held high for the whole transfer)
- m0_wr  in  1  master 0: 1=write, 0=read
- m0_addr  in  AW  master 0 address
- m0_din  in  DW  master 0 write data
- m0_grant  out  1  master 0 owns the bus
- m0_rvalid  out  1  m0_rdata valid this cycle
- m0_rdata  out  DW  read data to master 0
- m1_req, m1_wr, m1_addr, m1_din, m1_grant, m1_rvalid, m1_rdata: same as master 0, for master 1
- mem_cen  out  1  memory chip enable
- mem_wen  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data (registered in memory, valid 1 cycle after a read access)

Behaviour:
- Reset (reset_n=0, async): state=IDLE; hold_cnt=0; last=1; all outputs 0.
- FSM states: IDLE, GNT0, GNT1. Grants are decoded from registered state: m0_grant=(state==GNT0), m1_grant=(state==GNT1).
- IDLE transitions:
  - only m0_req -> GNT0
  - only m1_req -> GNT1
  - both -> priority rule (see Optional Feature)
  - none -> stay IDLE
- GNTx transitions:
  - mx_req=0 -> GNTy if my_req=1, else IDLE
  - mx_req=1, my_req=1 and hold_cnt==MAX_HOLD-1 -> forced switch to GNTy
  - otherwise stay in GNTx
- Switching is direct GNTx->GNTy with no idle cycle; grants are never both high.
- Grant latency: request seen at edge N, grant high from cycle N+1.
- hold_cnt: cleared on any state change and in IDLE. Increments each cycle in GNTx while my_req=1; holds while my_req=0. Saturates at MAX_HOLD-1.
- last: records the master granted most recently; updated on entry to GNT0/GNT1.
- Access cycle: a cycle where mx_grant & mx_req.
  - mem_cen = 1 during an access cycle.
  - mem_wen, mem_addr, mem_din = granted master's wr, addr, din (combinational mux).
  - All mem_* outputs are 0 when no access is in progress.
- Read return: access with wr=0 at edge N -> mx_rvalid=1 for exactly one cycle in N+1, with mx_rdata=mem_dout. rvalid is a registered tag of the access.
  - Both mx_rdata outputs carry mem_dout; only the tagged master's rvalid rises.
  - Writes produce no rvalid.
- Master drops req in the same cycle as a forced switch: the next state follows the normal release rule; no spurious access is issued.
- Reset mid-transfer: everything clears immediately. An in-flight rvalid is dropped and the memory sees cen=0.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requests, grant the master != last (round robin).
- Undefined: fixed priority, master 0 wins IDLE ties. The forced MAX_HOLD switch still applies in both builds.

Decomposition:
- Package mem_arb_pkg: state encoding constants (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10), AW/DW defaults.
- One sub-module, arb_hold_counter: clear/enable/saturate counter with a terminal flag, holding hold_cnt.
- FSM and mux stay in the top level.

Test Plan:
- Reset: reset_n=0 mid-run -> all grants, mem_cen and rvalids are 0 immediately; state IDLE.
- Single master write then read: m0 writes 32'h0000_0005 to addr 5'h05, then reads addr 5'h05. Expect m0_grant one cycle after req; m0_rvalid pulses one cycle after the read access with m0_rdata=32'h5.
- Contention, fixed priority: m0_req and m1_req rise together from IDLE. Expect GNT0 first; after MAX_HOLD=4 cycles the grant is forced to GNT1; m1 completes a read of addr 5'h0A.
- Round robin (macro defined): after an m0 transfer ends, both request together from IDLE -> GNT1 first.
- Release handoff: m1 holds, m0 waits; m1_req drops -> GNT0 on the next cycle with no idle cycle, and grants are never both high.
- Back-to-back reads of addrs 5'h01..5'h03 by m1 -> three consecutive m1_rvalid pulses with data 1, 2, 3 (memory preloaded); m0_rvalid stays 0.
